// File: rtl/if_fetch_unit.sv
// Fetch-stage controller: owns the PC, reads the combinational instruction memory
// and holds one instruction in the IF/ID slot behind a valid/ready handshake.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0073,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        vld_p1;
  logic [31:0] pc_p1;
  logic [31:0] instr_p1;
  logic [31:0] count_q;
  logic        accept;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  assign accept = (state_q == RUN) && (!vld_p1 || id_ready);

  // Stage p0 -> p1: PC drives memory, returned word lands in the IF/ID slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      vld_p1   <= 1'b0;
      pc_p1    <= 32'h0000_0000;
      instr_p1 <= NOP_INSTR;
      count_q  <= 32'h0000_0000;
    end else if (redirect_valid) begin
      // Flush wins over any capture or drain this cycle
      state_q  <= RUN;
      pc_q     <= word_align(redirect_pc);
      vld_p1   <= 1'b0;
      instr_p1 <= NOP_INSTR;
    end else begin
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (accept) begin
            vld_p1   <= 1'b1;
            pc_p1    <= pc_q;
            instr_p1 <= imem_instr;
            count_q  <= count_q + 32'd1;
            if (imem_instr == HALT_INSTR) begin
              state_q <= HALT;
            end else begin
              pc_q <= next_seq_pc(pc_q);
            end
          end else if (vld_p1 && id_ready) begin
            vld_p1 <= 1'b0;
          end
        end
        HALT: begin
          if (vld_p1 && id_ready) begin
            vld_p1 <= 1'b0;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign id_valid    = vld_p1;
  assign id_pc       = pc_p1;
  assign id_instr    = instr_p1;
  assign halted      = (state_q == HALT);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, async reset check, then
// randomized traffic compared against a cycle-level reference model.
module tb_if_fetch_unit;

  localparam logic [31:0] HALT_W = 32'h0000_0073;
  localparam logic [31:0] NOP_W  = 32'h0000_0013;
  localparam logic [31:0] WA = 32'hA000_0001;
  localparam logic [31:0] WB = 32'hB000_0002;
  localparam logic [31:0] WC = 32'hC000_0003;
  localparam logic [31:0] WD = 32'hD000_0004;
  localparam logic [31:0] WE = 32'hE000_0005;
  localparam logic [31:0] WG = 32'h6000_0007;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [256];

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[9:2]];

  if_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_pc         (id_pc),
    .id_instr      (id_instr),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_addr;
    logic        e_halt;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vt[21];

  function automatic vec_t mk(input logic redir, input logic [31:0] rpc, input logic rdy,
                              input logic ev, input logic [31:0] epc, input logic [31:0] ein,
                              input logic [31:0] eaddr, input logic eh, input logic [31:0] ecnt);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.rdy = rdy;
    v.e_valid = ev; v.e_pc = epc; v.e_instr = ein;
    v.e_addr = eaddr; v.e_halt = eh; v.e_cnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a PC, a one-entry slot and two mode flags
  logic [31:0] m_pc, m_spc, m_sinstr, m_cnt;
  logic        m_valid, m_booting, m_halted;

  task automatic model_reset();
    m_pc = 32'h0; m_spc = 32'h0; m_sinstr = NOP_W; m_cnt = 32'h0;
    m_valid = 1'b0; m_booting = 1'b1; m_halted = 1'b0;
  endtask

  task automatic model_step(input logic redir, input logic [31:0] rpc, input logic rdy);
    logic [31:0] w;
    if (redir) begin
      m_pc = rpc & 32'hFFFF_FFFC;
      m_valid = 1'b0; m_sinstr = NOP_W;
      m_booting = 1'b0; m_halted = 1'b0;
    end else if (m_booting) begin
      m_booting = 1'b0;
    end else if (!m_halted && (!m_valid || rdy)) begin
      w = mem[m_pc[9:2]];
      m_valid = 1'b1; m_spc = m_pc; m_sinstr = w; m_cnt = m_cnt + 1;
      if (w == HALT_W) m_halted = 1'b1;
      else m_pc = m_pc + 4;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    logic        r_redir, r_rdy;
    logic [31:0] r_rpc;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_1000 + i;
    mem[0] = WA; mem[1] = WB; mem[2] = WC; mem[3] = WD; mem[4] = HALT_W;
    mem[16] = WE; mem[255] = WG;

    vt[0]  = mk(0, 32'h0, 1, 0, 32'h0,  NOP_W,  32'h0,  0, 0);
    vt[1]  = mk(0, 32'h0, 1, 1, 32'h0,  WA,     32'h4,  0, 1);
    vt[2]  = mk(0, 32'h0, 1, 1, 32'h4,  WB,     32'h8,  0, 2);
    vt[3]  = mk(0, 32'h0, 0, 1, 32'h4,  WB,     32'h8,  0, 2);
    vt[4]  = mk(0, 32'h0, 0, 1, 32'h4,  WB,     32'h8,  0, 2);
    vt[5]  = mk(0, 32'h0, 0, 1, 32'h4,  WB,     32'h8,  0, 2);
    vt[6]  = mk(0, 32'h0, 1, 1, 32'h8,  WC,     32'hC,  0, 3);
    vt[7]  = mk(0, 32'h0, 1, 1, 32'hC,  WD,     32'h10, 0, 4);
    vt[8]  = mk(0, 32'h0, 0, 1, 32'hC,  WD,     32'h10, 0, 4);
    vt[9]  = mk(1, 32'h43, 0, 0, 32'h0, NOP_W,  32'h40, 0, 4);
    vt[10] = mk(0, 32'h0, 1, 1, 32'h40, WE,     32'h44, 0, 5);
    vt[11] = mk(1, 32'h10, 1, 0, 32'h0, NOP_W,  32'h10, 0, 5);
    vt[12] = mk(0, 32'h0, 0, 1, 32'h10, HALT_W, 32'h10, 1, 6);
    vt[13] = mk(0, 32'h0, 0, 1, 32'h10, HALT_W, 32'h10, 1, 6);
    vt[14] = mk(0, 32'h0, 1, 0, 32'h0,  NOP_W,  32'h10, 1, 6);
    vt[15] = mk(0, 32'h0, 1, 0, 32'h0,  NOP_W,  32'h10, 1, 6);
    vt[16] = mk(1, 32'h0, 1, 0, 32'h0,  NOP_W,  32'h0,  0, 6);
    vt[17] = mk(0, 32'h0, 1, 1, 32'h0,  WA,     32'h4,  0, 7);
    vt[18] = mk(1, 32'hFFFF_FFFF, 1, 0, 32'h0, NOP_W, 32'hFFFF_FFFC, 0, 7);
    vt[19] = mk(0, 32'h0, 1, 1, 32'hFFFF_FFFC, WG, 32'h0, 0, 8);
    vt[20] = mk(0, 32'h0, 1, 1, 32'h0,  WA,     32'h4,  0, 9);

    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset id_valid", {31'h0, id_valid}, 32'h0);
    chk("reset id_pc", id_pc, 32'h0);
    chk("reset id_instr", id_instr, NOP_W);
    chk("reset imem_addr", imem_addr, 32'h0);
    chk("reset halted", {31'h0, halted}, 32'h0);
    chk("reset fetch_count", fetch_count, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      redirect_valid = vt[i].redir;
      redirect_pc    = vt[i].rpc;
      id_ready       = vt[i].rdy;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("row%0d id_valid", i), {31'h0, id_valid}, {31'h0, vt[i].e_valid});
      chk($sformatf("row%0d imem_addr", i), imem_addr, vt[i].e_addr);
      chk($sformatf("row%0d halted", i), {31'h0, halted}, {31'h0, vt[i].e_halt});
      chk($sformatf("row%0d fetch_count", i), fetch_count, vt[i].e_cnt);
      if (vt[i].e_valid) chk($sformatf("row%0d id_pc", i), id_pc, vt[i].e_pc);
      if (vt[i].e_valid || vt[i].redir)
        chk($sformatf("row%0d id_instr", i), id_instr, vt[i].e_instr);
    end
    redirect_valid = 1'b0;

    // Asynchronous reset between edges while streaming
    id_ready = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async id_valid", {31'h0, id_valid}, 32'h0);
    chk("async imem_addr", imem_addr, 32'h0);
    chk("async fetch_count", fetch_count, 32'h0);
    chk("async id_instr", id_instr, NOP_W);
    chk("async halted", {31'h0, halted}, 32'h0);

    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? HALT_W : $urandom;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    for (int c = 0; c < 3000; c++) begin
      chk("rnd id_valid", {31'h0, id_valid}, {31'h0, m_valid});
      chk("rnd imem_addr", imem_addr, m_pc);
      chk("rnd halted", {31'h0, halted}, {31'h0, m_halted});
      chk("rnd fetch_count", fetch_count, m_cnt);
      if (m_valid) begin
        chk("rnd id_pc", id_pc, m_spc);
        chk("rnd id_instr", id_instr, m_sinstr);
      end
      r_redir = ($urandom_range(0, 11) == 0);
      r_rpc   = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 1023);
      r_rdy   = ($urandom_range(0, 3) != 0);
      redirect_valid = r_redir;
      redirect_pc    = r_rpc;
      id_ready       = r_rdy;
      @(posedge clk);
      model_step(r_redir, r_rpc, r_rdy);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
